spi_mem_arbiter: RTL and testbench
==================================

Name: spi_mem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one spi_mem_emu-style memory port between NUM_REQ requesters.
- Memory side uses a four-phase en/valid handshake:
  - the arbiter raises en and holds the command stable;
  - the memory raises valid;
  - the arbiter drops en;
  - the memory drops valid.
- Each requester sees a level request and a one-cycle completion pulse with read data.
- Sits between the host-side agents (command decoder, test sequencer) and the memory emulator.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- AW, 6, address width. Must match the memory port.
- DW, 8, data width.
- TIMEOUT_CYCLES, 32, watchdog limit in cycles of en high. Used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req  in  NUM_REQ  per-requester request level.
- req_wr_en  in  NUM_REQ  per-requester write(1)/read(0).
- req_addr  in  NUM_REQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wr_data  in  NUM_REQ*DW  packed write data; requester i at [i*DW +: DW].
- done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rd_data  out  DW  read data. Valid in the done cycle and held until the next completion.
- rsp_err  out  1  timeout flag, qualified by done.
- busy  out  1  high whenever the FSM is not in IDLE.
- mem_en  out  1  memory handshake request.
- mem_wr_en  out  1  memory command.
- mem_addr  out  AW  memory command.
- mem_wr_data  out  DW  memory command.
- mem_valid  in  1  memory handshake acknowledge.
- mem_rd_data  in  DW  memory read data.

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, rr pointer=0, FSM=DRAIN. Reset mid-transaction drops mem_en on the next edge.
- FSM states:
  - DRAIN: wait for mem_valid==0, then go to IDLE. Covers a memory still finishing a transaction aborted by reset.
  - IDLE: if any req bit is set, pick the first set bit searching upward (modulo NUM_REQ) from the rr pointer. On the same edge:
    - register the grant index;
    - copy that requester's wr_en/addr/wr_data into mem_*;
    - set mem_en=1 and go to ACCESS.
    - If no req bit is set, stay in IDLE.
  - ACCESS: mem_en=1 and mem_* held constant. On the first posedge with mem_valid=1:
    - rsp_rd_data<=mem_rd_data on reads; unchanged on writes;
    - done[grant]<=1 for exactly one cycle, rsp_err<=0;
    - mem_en<=0;
    - rr pointer<=grant+1 (wraps to 0 after NUM_REQ-1);
    - go to RELEASE.
  - RELEASE: mem_en=0. When mem_valid==0, go to IDLE.
- Latency: the first cycle req is seen in IDLE leads to mem_en high after 1 edge. Completion is mem_valid high plus 1 edge. The minimum gap between transactions is 2 cycles (RELEASE, IDLE).
- Requester rules:
  - req is a level; each done pulse consumes one transaction.
  - A requester holding req after done is re-arbitrated as a new transaction. It must drop req in the done cycle if it has nothing further.
  - Command inputs are sampled only at grant; changing them afterwards has no effect.
  - req dropped during ACCESS does not abort: the transaction completes and done still pulses.
- Simultaneous requests are resolved by the rr pointer only. No requester can be starved; the worst-case wait is NUM_REQ-1 transactions.
- mem_valid high while in IDLE is ignored; no grant occurs until it clears (IDLE arbitrates only when mem_valid==0).
- done is never asserted for more than one bit or for more than one cycle.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - a counter clears on entry to ACCESS and increments every ACCESS cycle;
  - when it reaches TIMEOUT_CYCLES with mem_valid still low, the block pulses done[grant] with rsp_err=1, leaves rsp_rd_data unchanged, sets mem_en<=0, advances the rr pointer and goes to RELEASE.
- Not defined: no counter; rsp_err is tied 0; ACCESS waits indefinitely.

Test Plan:
- Single read: preload mem[5]=8'hA5; req[0] with addr 5, read -> mem_en high 1 cycle after req, done[0] one cycle after valid, rsp_rd_data=8'hA5, rsp_err=0.
- Write then read back: req[2] writes 8'h3C to addr 63, then reads addr 63 -> second done[2] gives rsp_rd_data=8'h3C; mem_addr stable at 63 throughout each en-high window.
- Contention: req=4'b1111 held, rr pointer=0 -> grant order 0,1,2,3,0; exactly one done bit per transaction; mem_en low for at least 1 cycle between transactions.
- Request withdrawn: req[1] dropped 2 cycles after grant -> transaction still completes, done[1] pulses, no second grant to requester 1.
- Reset mid-ACCESS: rst pulsed 3 cycles after en rises -> mem_en=0 next edge; FSM stays in DRAIN until emulator valid falls; a subsequent req[3] is served correctly.
- Timeout (macro on, TIMEOUT_CYCLES=4, memory never asserts valid) -> done[0] with rsp_err=1 on the 4th ACCESS cycle, mem_en falls, rsp_rd_data unchanged.

Source files
------------

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter
// ---------------
// Round-robin arbiter and sequencer that shares one memory port, driven with
// a four-phase en/valid handshake, between NUM_REQ requesters.
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   req          per-requester request level
//   req_wr_en    per-requester write(1)/read(0)
//   req_addr     packed addresses, requester i at [i*AW +: AW]
//   req_wr_data  packed write data, requester i at [i*DW +: DW]
//   done         one-hot, one-cycle completion pulse
//   rsp_rd_data  read data, valid in the done cycle, held until next completion
//   rsp_err      timeout flag, qualified by done
//   busy         high whenever the sequencer is not idle
//   mem_en, mem_wr_en, mem_addr, mem_wr_data   memory command / handshake
//   mem_valid, mem_rd_data                     memory acknowledge / read data
//
// Build option
//   SPI_ARB_TIMEOUT_EN  when defined, an access that sees no mem_valid for
//                       TIMEOUT_CYCLES cycles completes with rsp_err=1.
//                       When undefined, rsp_err is tied low and an access
//                       waits indefinitely.

module spi_mem_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int AW             = 6,
    parameter int DW             = 8,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_wr_en,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wr_data,
    output logic [NUM_REQ-1:0]    done,
    output logic [DW-1:0]         rsp_rd_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_wr_en,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wr_data,
    input  logic                  mem_valid,
    input  logic [DW-1:0]         mem_rd_data
);

    localparam int            IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("spi_mem_arbiter: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_DRAIN   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [IW-1:0]      rr_r, rr_s, grant_r, grant_s, rr_after_s, pick_idx_s;
    logic [IW:0]        pick_s;
    logic [NUM_REQ-1:0] done_r, done_s, grant_onehot_s;
    logic [DW-1:0]      rd_data_r, rd_data_s;
    logic               mem_en_r, mem_en_s, mem_wr_en_r, mem_wr_en_s, busy_r;
    logic [AW-1:0]      mem_addr_r, mem_addr_s;
    logic [DW-1:0]      mem_wr_data_r, mem_wr_data_s;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt_r, to_cnt_s;
    logic          rsp_err_r, rsp_err_s;
`endif

    // First set request bit at or above start, wrapping modulo NUM_REQ.
    // Returns {found, index}; scanning offsets downward lets the smallest
    // offset overwrite the result last.
    function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [IW-1:0]      start);
        logic [IW:0]   res;
        logic [IW-1:0] idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((32'(start) + 32'(k)) % 32'(NUM_REQ));
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign pick_s         = rr_pick(req, rr_r);
    assign pick_idx_s     = pick_s[IW-1:0];
    assign rr_after_s     = (grant_r == LAST_IDX) ? '0 : grant_r + IW'(1);
    assign grant_onehot_s = NUM_REQ'(1) << grant_r;

    // Next-state, command capture and completion decode
    always_comb begin
        state_s       = state_r;
        rr_s          = rr_r;
        grant_s       = grant_r;
        done_s        = '0;
        rd_data_s     = rd_data_r;
        mem_en_s      = mem_en_r;
        mem_wr_en_s   = mem_wr_en_r;
        mem_addr_s    = mem_addr_r;
        mem_wr_data_s = mem_wr_data_r;
`ifdef SPI_ARB_TIMEOUT_EN
        to_cnt_s      = to_cnt_r;
        rsp_err_s     = rsp_err_r;
`endif
        case (state_r)
            ST_DRAIN: begin
                // memory may still be finishing a transaction cut by reset
                mem_en_s = 1'b0;
                if (!mem_valid) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_IDLE: begin
                // a stray valid blocks arbitration until it clears
                if (!mem_valid && pick_s[IW]) begin
                    grant_s       = pick_idx_s;
                    mem_en_s      = 1'b1;
                    mem_wr_en_s   = req_wr_en[pick_idx_s];
                    mem_addr_s    = req_addr[32'(pick_idx_s) * AW +: AW];
                    mem_wr_data_s = req_wr_data[32'(pick_idx_s) * DW +: DW];
                    state_s       = ST_ACCESS;
`ifdef SPI_ARB_TIMEOUT_EN
                    to_cnt_s      = '0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_valid) begin
                    if (!mem_wr_en_r) begin
                        rd_data_s = mem_rd_data;
                    end else begin
                        rd_data_s = rd_data_r;
                    end
                    done_s   = grant_onehot_s;
                    mem_en_s = 1'b0;
                    rr_s     = rr_after_s;
                    state_s  = ST_RELEASE;
`ifdef SPI_ARB_TIMEOUT_EN
                    rsp_err_s = 1'b0;
`endif
                end else begin
`ifdef SPI_ARB_TIMEOUT_EN
                    // counter holds the number of ACCESS cycles already spent
                    if (to_cnt_r == CW'(TIMEOUT_CYCLES - 1)) begin
                        done_s    = grant_onehot_s;
                        rsp_err_s = 1'b1;
                        mem_en_s  = 1'b0;
                        rr_s      = rr_after_s;
                        state_s   = ST_RELEASE;
                    end else begin
                        to_cnt_s  = to_cnt_r + CW'(1);
                    end
`else
                    state_s = ST_ACCESS;
`endif
                end
            end
            ST_RELEASE: begin
                mem_en_s = 1'b0;
                if (!mem_valid) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RELEASE;
                end
            end
            default: begin
                mem_en_s = 1'b0;
                state_s  = ST_DRAIN;
            end
        endcase
    end

    // State, pointer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_DRAIN;
            rr_r          <= '0;
            grant_r       <= '0;
            done_r        <= '0;
            rd_data_r     <= '0;
            mem_en_r      <= 1'b0;
            mem_wr_en_r   <= 1'b0;
            mem_addr_r    <= '0;
            mem_wr_data_r <= '0;
            busy_r        <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt_r      <= '0;
            rsp_err_r     <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            rr_r          <= rr_s;
            grant_r       <= grant_s;
            done_r        <= done_s;
            rd_data_r     <= rd_data_s;
            mem_en_r      <= mem_en_s;
            mem_wr_en_r   <= mem_wr_en_s;
            mem_addr_r    <= mem_addr_s;
            mem_wr_data_r <= mem_wr_data_s;
            busy_r        <= (state_s != ST_IDLE);
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt_r      <= to_cnt_s;
            rsp_err_r     <= rsp_err_s;
`endif
        end
    end

    assign done        = done_r;
    assign rsp_rd_data = rd_data_r;
    assign busy        = busy_r;
    assign mem_en      = mem_en_r;
    assign mem_wr_en   = mem_wr_en_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wr_data = mem_wr_data_r;
`ifdef SPI_ARB_TIMEOUT_EN
    assign rsp_err     = rsp_err_r;
`else
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Self-checking bench for spi_mem_arbiter: a memory emulator answering the
// en/valid handshake, a table of single transactions, hand-written corner
// sequences, and a random phase checked against a round-robin reference model.

module tb_spi_mem_arbiter;

    localparam int NR = 4;
    localparam int AW = 6;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req, req_wr_en;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wr_data;
    logic [NR-1:0]   done;
    logic [DW-1:0]   rsp_rd_data;
    logic            rsp_err, busy, mem_en, mem_wr_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wr_data;
    logic            mem_valid;
    logic [DW-1:0]   mem_rd_data;

    spi_mem_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr_en(req_wr_en),
        .req_addr(req_addr), .req_wr_data(req_wr_data), .done(done),
        .rsp_rd_data(rsp_rd_data), .rsp_err(rsp_err), .busy(busy),
        .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_valid(mem_valid), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory emulator ----------------
    logic [7:0] emu_mem [64];
    logic [7:0] ref_mem [64];
    int  emu_lat  = 1;
    int  emu_wait = 0;
    bit  emu_rand = 1'b0;
    bit  emu_stuck = 1'b0;
    bit  emu_force = 1'b0;

    task automatic emu_step();
        if (emu_force) begin
            mem_valid = 1'b1;
        end else if (!mem_valid) begin
            if (mem_en && !emu_stuck) begin
                if (emu_wait >= emu_lat) begin
                    if (mem_wr_en) emu_mem[mem_addr] = mem_wr_data;
                    mem_rd_data = emu_mem[mem_addr];
                    mem_valid   = 1'b1;
                    emu_wait    = 0;
                end else begin
                    emu_wait++;
                end
            end else begin
                emu_wait = 0;
                if (emu_rand) emu_lat = $urandom_range(3, 0);
            end
        end else if (!mem_en) begin
            if (!emu_rand || $urandom_range(1, 0) == 1) mem_valid = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        emu_step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        check("rst_done",    32'(done),        32'd0);
        check("rst_rd",      32'(rsp_rd_data), 32'd0);
        check("rst_err",     32'(rsp_err),     32'd0);
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_en",      32'(mem_en),      32'd0);
        check("rst_wr_en",   32'(mem_wr_en),   32'd0);
        check("rst_addr",    32'(mem_addr),    32'd0);
        check("rst_wr_data", 32'(mem_wr_data), 32'd0);
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((busy || mem_valid) && c < 50) begin
            tick();
            c++;
        end
        check("idle_reached", 32'(c < 50), 32'd1);
    endtask

    // ---------------- reference model ----------------
    int         rr_m;
    int         pending [NR];
    bit         in_txn;
    int         t_idx;
    logic       t_wr;
    logic [5:0] t_addr;
    logic [7:0] t_wd;
    logic [7:0] last_rd;

    function automatic int rr_first(input logic [NR-1:0] r, input int start);
        for (int k = 0; k < NR; k++) begin
            if (r[(start + k) % NR]) return (start + k) % NR;
        end
        return -1;
    endfunction

    task automatic cycle_rand(input bit arrive);
        logic [NR-1:0]    sreq, sw;
        logic [NR*AW-1:0] sa;
        logic [NR*DW-1:0] sd;
        logic             pv, pb, pen;
        int               g;
        sreq = req; sw = req_wr_en; sa = req_addr; sd = req_wr_data;
        pv = mem_valid; pb = busy; pen = mem_en;
        tick();
        // idle, no stray valid and a request pending: grant must follow at once
        if (!pb && !pv && sreq != '0) check("grant_latency", 32'(mem_en), 32'd1);
        if (mem_en && !pen) begin
            check("grant_has_req", 32'(sreq != '0), 32'd1);
            g = rr_first(sreq, rr_m);
            if (g >= 0) begin
                check("grant_addr", 32'(mem_addr), 32'(sa[g*AW +: AW]));
                check("grant_wr", 32'(mem_wr_en), 32'(sw[g]));
                if (sw[g]) check("grant_wdata", 32'(mem_wr_data), 32'(sd[g*DW +: DW]));
                in_txn = 1'b1;
                t_idx  = g;
                t_wr   = sw[g];
                t_addr = sa[g*AW +: AW];
                t_wd   = sd[g*DW +: DW];
            end
        end else if (mem_en && in_txn) begin
            check("hold_addr", 32'(mem_addr), 32'(t_addr));
        end
        if (done != '0) begin
            check("done_expected", 32'(in_txn), 32'd1);
            if (in_txn) begin
                check("done_onehot", 32'(done), 32'(4'd1 << t_idx));
                check("done_err", 32'(rsp_err), 32'd0);
                if (t_wr) ref_mem[t_addr] = t_wd;
                else      last_rd = ref_mem[t_addr];
                check("rsp_rd_data", 32'(rsp_rd_data), 32'(last_rd));
                rr_m = (t_idx + 1) % NR;
                pending[t_idx]--;
                in_txn = 1'b0;
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (arrive && pending[i] == 0 && $urandom_range(5, 0) == 0)
                pending[i] = $urandom_range(3, 1);
            if ($urandom_range(1, 0) == 1) begin
                req_wr_en[i]            = 1'($urandom_range(1, 0));
                req_addr[i*AW +: AW]    = 6'($urandom_range(63, 0));
                req_wr_data[i*DW +: DW] = 8'($urandom_range(255, 0));
            end
            req[i] = (pending[i] > 0);
        end
    endtask

    typedef struct {
        int         idx;
        logic       wr;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vt [6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found, saw;
        int n, guard, any;
        vt[0] = '{0, 1'b0, 6'd5,  8'h00, 8'hA5};
        vt[1] = '{2, 1'b1, 6'd63, 8'h3C, 8'hA5};
        vt[2] = '{2, 1'b0, 6'd63, 8'h00, 8'h3C};
        vt[3] = '{1, 1'b1, 6'd0,  8'h5A, 8'h3C};
        vt[4] = '{3, 1'b0, 6'd0,  8'h00, 8'h5A};
        vt[5] = '{1, 1'b0, 6'd5,  8'hFF, 8'hA5};

        for (int a = 0; a < 64; a++) begin
            emu_mem[a] = 8'h00;
            ref_mem[a] = 8'h00;
        end
        emu_mem[5] = 8'hA5;
        ref_mem[5] = 8'hA5;
        rst = 1'b1; req = '0; req_wr_en = '0; req_addr = '0; req_wr_data = '0;
        mem_valid = 1'b0; mem_rd_data = '0;

        do_reset();

        // ---- table of single transactions ----
        emu_lat = 1;
        for (int v = 0; v < 6; v++) begin
            int i;
            i = vt[v].idx;
            req_wr_en[i]            = vt[v].wr;
            req_addr[i*AW +: AW]    = vt[v].addr;
            req_wr_data[i*DW +: DW] = vt[v].wdata;
            req[i] = 1'b1;
            tick();
            check("t_en_latency", 32'(mem_en), 32'd1);
            check("t_addr", 32'(mem_addr), 32'(vt[v].addr));
            check("t_wr_en", 32'(mem_wr_en), 32'(vt[v].wr));
            // late command changes must not reach the memory
            req_addr[i*AW +: AW]    = ~vt[v].addr;
            req_wr_data[i*DW +: DW] = ~vt[v].wdata;
            found = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                tick();
                if (done != '0) found = 1'b1;
                else if (mem_en) check("t_addr_hold", 32'(mem_addr), 32'(vt[v].addr));
            end
            req[i] = 1'b0;
            check("t_done_seen", 32'(found), 32'd1);
            check("t_done", 32'(done), 32'(4'd1 << i));
            check("t_rd", 32'(rsp_rd_data), 32'(vt[v].exp_rd));
            check("t_err", 32'(rsp_err), 32'd0);
            check("t_en_low", 32'(mem_en), 32'd0);
            if (vt[v].wr) begin
                check("t_wdata", 32'(mem_wr_data), 32'(vt[v].wdata));
                ref_mem[vt[v].addr] = vt[v].wdata;
            end
            wait_idle();
        end

        // ---- contention: all four requesting, pointer 0 after reset ----
        do_reset();
        emu_lat = 0;
        for (int i = 0; i < NR; i++) begin
            req_wr_en[i] = 1'b0;
            req_addr[i*AW +: AW] = 6'(i);
        end
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            found = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                tick();
                if (done != '0) found = 1'b1;
            end
            if (t == 4) req = '0;
            check("c_done", 32'(done), 32'(4'd1 << (t % NR)));
            check("c_en_low", 32'(mem_en), 32'd0);
            tick();
            check("c_gap", 32'(mem_en), 32'd0);
            check("c_done_single", 32'(done), 32'd0);
        end
        wait_idle();

        // ---- request withdrawn during ACCESS ----
        emu_lat = 5;
        req_wr_en[1] = 1'b0;
        req_addr[1*AW +: AW] = 6'd5;
        req[1] = 1'b1;
        tick();
        check("w_en", 32'(mem_en), 32'd1);
        tick();
        tick();
        req[1] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (done != '0) found = 1'b1;
        end
        check("w_done", 32'(done), 32'b0010);
        check("w_rd", 32'(rsp_rd_data), 32'h0000_00A5);
        saw = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (mem_en) saw = 1'b1;
        end
        check("w_no_regrant", 32'(saw), 32'd0);

        // ---- reset in the middle of ACCESS ----
        emu_lat = 1;
        emu_stuck = 1'b1;
        req_wr_en[3] = 1'b0;
        req_addr[3*AW +: AW] = 6'd5;
        req[3] = 1'b1;
        tick();
        check("r_en", 32'(mem_en), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        emu_force = 1'b1;     // memory is still acknowledging the aborted access
        tick();
        check("r_en_drop", 32'(mem_en), 32'd0);
        check("r_no_done", 32'(done), 32'd0);
        rst = 1'b0;
        emu_stuck = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("r_drain_busy", 32'(busy), 32'd1);
            check("r_drain_en", 32'(mem_en), 32'd0);
        end
        emu_force = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (done != '0) found = 1'b1;
        end
        req[3] = 1'b0;
        check("r_done", 32'(done), 32'b1000);
        check("r_rd", 32'(rsp_rd_data), 32'h0000_00A5);
        wait_idle();

        // ---- randomized traffic against the reference model ----
        do_reset();
        rr_m = 0; in_txn = 1'b0; last_rd = 8'h00;
        for (int i = 0; i < NR; i++) pending[i] = 0;
        emu_rand = 1'b1;
        for (int c = 0; c < 1500; c++) cycle_rand(1'b1);
        guard = 0;
        any = 1;
        while (any != 0 && guard < 500) begin
            cycle_rand(1'b0);
            guard++;
            any = (in_txn || busy) ? 1 : 0;
            for (int i = 0; i < NR; i++) if (pending[i] != 0) any = 1;
        end
        check("rand_drained", 32'(guard < 500), 32'd1);
        emu_rand = 1'b0;
        emu_lat = 1;
        wait_idle();

`ifdef SPI_ARB_TIMEOUT_EN
        // ---- watchdog timeout with a silent memory ----
        emu_stuck = 1'b1;
        req_wr_en[0] = 1'b0;
        req_addr[0 +: AW] = 6'd5;
        req[0] = 1'b1;
        tick();
        check("to_en", 32'(mem_en), 32'd1);
        n = 0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            n++;
            if (done != '0) found = 1'b1;
        end
        req[0] = 1'b0;
        check("to_cycles", 32'(n), 32'd4);
        check("to_done", 32'(done), 32'b0001);
        check("to_err", 32'(rsp_err), 32'd1);
        check("to_rd_kept", 32'(rsp_rd_data), 32'(last_rd));
        check("to_en_low", 32'(mem_en), 32'd0);
        emu_stuck = 1'b0;
        wait_idle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
